// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: upstream offer, downstream head, and flush.
// The master modport is the side that feeds the stage and consumes its output; slave is the stage.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 2
);
  logic [LANES-1:0]       in_valid;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   in_ready;
  logic [LANES-1:0]       out_valid;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   out_ready;
  logic                   flush;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Multi-lane ready/valid pipeline register with flush; 1-cycle latency, 1 bundle/cycle.
// PIPE_STAGE_SKID_EN: two-entry skid with registered in_ready; otherwise single register with combinational in_ready.
module pipe_stage_reg #(
  parameter int          WIDTH = 32,
  parameter int          LANES = 2,
  parameter logic [31:0] RESET = 32'h0000_3000
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  localparam logic [WIDTH-1:0]       RST_LANE = WIDTH'(RESET);
  localparam logic [LANES*WIDTH-1:0] RST_BUS  = {LANES{RST_LANE}};

  logic [LANES-1:0]       main_v;
  logic [LANES*WIDTH-1:0] main_d;
  logic                   present;
  logic                   accept;
  logic                   rel;

  // An all-zero valid mask is not a bundle, so it is never stored.
  assign present       = |bus.in_valid;
  assign rel           = (|main_v) && bus.out_ready;
  assign bus.out_valid = main_v;
  assign bus.out_data  = main_d;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t                 state;
  logic                   rdy_q;
  logic [LANES-1:0]       skid_v;
  logic [LANES*WIDTH-1:0] skid_d;

  // Upstream sees only a flop, so back-pressure never chains combinationally.
  assign bus.in_ready = rdy_q;
  assign accept       = present && rdy_q && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      rdy_q  <= 1'b0;
      main_v <= '0;
      main_d <= RST_BUS;
      skid_v <= '0;
      skid_d <= RST_BUS;
    end else if (bus.flush) begin
      state  <= EMPTY;
      rdy_q  <= 1'b1;
      main_v <= '0;
      skid_v <= '0;
    end else begin
      case (state)
        EMPTY: begin
          rdy_q <= 1'b1;
          if (accept) begin
            main_v <= bus.in_valid;
            main_d <= bus.in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && rel) begin
            main_v <= bus.in_valid;
            main_d <= bus.in_data;
          end else if (accept) begin
            // Head is stalled: park the new bundle behind it and close the door.
            skid_v <= bus.in_valid;
            skid_d <= bus.in_data;
            state  <= TWO;
            rdy_q  <= 1'b0;
          end else if (rel) begin
            main_v <= '0;
            state  <= EMPTY;
          end
        end
        TWO: begin
          if (rel) begin
            main_v <= skid_v;
            main_d <= skid_d;
            skid_v <= '0;
            state  <= ONE;
            rdy_q  <= 1'b1;
          end
        end
        default: begin
          state  <= EMPTY;
          rdy_q  <= 1'b1;
          main_v <= '0;
          skid_v <= '0;
        end
      endcase
    end
  end

`else

  // Without skid storage the stage can only take a bundle if the head leaves this cycle.
  assign bus.in_ready = !(|main_v) || bus.out_ready;
  assign accept       = present && bus.in_ready && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v <= '0;
      main_d <= RST_BUS;
    end else if (bus.flush) begin
      main_v <= '0;
    end else if (accept) begin
      main_v <= bus.in_valid;
      main_d <= bus.in_data;
    end else if (rel) begin
      main_v <= '0;
    end
  end

`endif

endmodule
